// File: rtl/bn_coef_loader.sv
// Purpose: serial-to-parallel loader for BN/ReLU per-channel scale (a) and bias (b) coefficients.
//          A full NO_CH set is assembled in a shadow bank. It is committed atomically to the active bank only while the pipeline is idle.
// Ports:   clk/rst (sync, active-high); coef_* valid/ready beat stream; pipe_busy commit gate;
//          a/b active vectors; coef_valid, swap pulse and sticky err_len status.
module bn_coef_loader #(
    parameter int NO_CH = 10,
    parameter int BW_A  = 12,
    parameter int BW_B  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coef_vld,
    output logic                       coef_rdy,
    input  logic [BW_A-1:0]            coef_a,
    input  logic [BW_B-1:0]            coef_b,
    input  logic                       coef_last,
    input  logic                       pipe_busy,
    output logic [NO_CH-1:0][BW_A-1:0] a,
    output logic [NO_CH-1:0][BW_B-1:0] b,
    output logic                       coef_valid,
    output logic                       swap,
    output logic                       err_len
);

    localparam int IW = (NO_CH > 1) ? $clog2(NO_CH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NO_CH - 1);

    typedef enum logic {
        LOAD = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              idx_nxt;
    logic                       err_set;
    logic                       commit;
    logic                       accept;
    logic [NO_CH-1:0][BW_A-1:0] sh_a;
    logic [NO_CH-1:0][BW_B-1:0] sh_b;

    // Ready depends on state only, and is held low during reset so that no beat can slip into a bank that is being cleared.
    assign coef_rdy = !rst && (state == LOAD);
    assign accept   = coef_vld && coef_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_set   = 1'b0;
        commit    = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    if ((idx == LAST_IDX) && coef_last) begin
                        state_nxt = PEND;
                        idx_nxt   = '0;
                    end else if ((idx != LAST_IDX) && !coef_last) begin
                        idx_nxt = idx + 1'b1;
                    end else begin
                        // A set is either too short or too long. Drop it and treat the next beat as channel 0.
                        err_set = 1'b1;
                        idx_nxt = '0;
                    end
                end
            end
            PEND: begin
                if (!pipe_busy) begin
                    commit    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
                idx_nxt   = '0;
            end
        endcase
    end

    // The shadow bank has no reset. A commit is only reached after every channel has been rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            sh_a[idx] <= coef_a;
            sh_b[idx] <= coef_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a          <= '0;
            b          <= '0;
            coef_valid <= 1'b0;
            swap       <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            swap <= commit;
            if (commit) begin
                a          <= sh_a;
                b          <= sh_b;
                coef_valid <= 1'b1;
            end
            if (err_set) begin
                err_len <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bn_coef_loader.sv
// Purpose: scoreboard bench for bn_coef_loader. The driver feeds beats and a set-level model that predicts commits.
// A negedge monitor pops predictions on swap and checks the active bank, coef_valid and err_len every cycle.
// Ports: none (top-level bench).
module tb_bn_coef_loader;

    localparam int NO_CH = 10;
    localparam int BW_A  = 12;
    localparam int BW_B  = 12;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       coef_vld = 1'b0;
    logic                       coef_rdy;
    logic [BW_A-1:0]            coef_a = '0;
    logic [BW_B-1:0]            coef_b = '0;
    logic                       coef_last = 1'b0;
    logic                       pipe_busy = 1'b0;
    logic [NO_CH-1:0][BW_A-1:0] a;
    logic [NO_CH-1:0][BW_B-1:0] b;
    logic                       coef_valid;
    logic                       swap;
    logic                       err_len;

    bn_coef_loader #(.NO_CH(NO_CH), .BW_A(BW_A), .BW_B(BW_B)) dut (
        .clk(clk), .rst(rst), .coef_vld(coef_vld), .coef_rdy(coef_rdy),
        .coef_a(coef_a), .coef_b(coef_b), .coef_last(coef_last), .pipe_busy(pipe_busy),
        .a(a), .b(b), .coef_valid(coef_valid), .swap(swap), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NO_CH-1:0][BW_A-1:0] va;
        logic [NO_CH-1:0][BW_B-1:0] vb;
    } set_t;

    // Model state: predicted commits, the active bank, and the beats of the set currently being received.
    set_t                       exp_q[$];
    logic [NO_CH-1:0][BW_A-1:0] act_a = '0;
    logic [NO_CH-1:0][BW_B-1:0] act_b = '0;
    logic                       exp_valid = 1'b0;
    logic                       exp_err = 1'b0;
    logic [BW_A-1:0]            cur_a[$];
    logic [BW_B-1:0]            cur_b[$];
    bit                         mon_on = 1'b0;
    int                         n_chk = 0;
    int                         n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A set is valid only when it has exactly NO_CH beats and the last flag is on the final beat.
    task automatic model_accept(input logic [BW_A-1:0] va, input logic [BW_B-1:0] vb, input logic last);
        set_t s;
        cur_a.push_back(va);
        cur_b.push_back(vb);
        if (last || cur_a.size() == NO_CH) begin
            if (last && cur_a.size() == NO_CH) begin
                for (int i = 0; i < NO_CH; i++) begin
                    s.va[i] = cur_a[i];
                    s.vb[i] = cur_b[i];
                end
                exp_q.push_back(s);
            end else begin
                exp_err = 1'b1;
            end
            cur_a.delete();
            cur_b.delete();
        end
    endtask

    // Present one beat and hold it until it is accepted. Returns 1 ns after the accepting edge.
    // When rand_busy is set, pipe_busy is re-randomised while the beat is waiting.
    task automatic send_beat(input logic [BW_A-1:0] va, input logic [BW_B-1:0] vb, input logic last,
                             input bit rand_busy);
        logic r;
        int   waited;
        coef_vld  = 1'b1;
        coef_a    = va;
        coef_b    = vb;
        coef_last = last;
        waited    = 0;
        forever begin
            @(negedge clk);
            r = coef_rdy;
            @(posedge clk);
            #1;
            if (r) break;
            if (rand_busy) pipe_busy = ($urandom_range(0, 2) == 0);
            waited++;
            if (waited > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL beat_accept_timeout: got no ready after %0d cycles, expected ready", waited);
                break;
            end
        end
        if (r) model_accept(va, vb, last);
    endtask

    task automatic idle(input int n);
        coef_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited;
        coef_vld  = 1'b0;
        pipe_busy = 1'b0;
        waited    = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        @(negedge clk);
        chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_set(input int base, input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) begin
            send_beat(BW_A'(base + k), BW_B'(-(base + k)), (k == last_at), 1'b0);
        end
        coef_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        cur_a.delete();
        cur_b.delete();
        act_a     = '0;
        act_b     = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        @(negedge clk);
        chk("rdy_low_in_reset", 128'(coef_rdy), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: consumes a prediction on each swap and checks the visible state each cycle.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (swap) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_swap: got swap=1 expected no pending commit at %0t", $time);
                end else begin
                    set_t e;
                    e = exp_q.pop_front();
                    act_a     = e.va;
                    act_b     = e.vb;
                    exp_valid = 1'b1;
                end
            end
            chk("active_a", 128'(a), 128'(act_a));
            chk("active_b", 128'(b), 128'(act_b));
            chk("coef_valid", 128'(coef_valid), 128'(exp_valid));
            chk("err_len", 128'(err_len), 128'(exp_err));
        end
    end

    initial begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_a", 128'(a), 128'd0);
        chk("reset_swap", 128'(swap), 128'd0);
        chk("reset_valid", 128'(coef_valid), 128'd0);
        chk("reset_rdy", 128'(coef_rdy), 128'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", 128'(coef_rdy), 128'd1);

        // Nominal: a=k+1, b=-(k+1). The new values become visible two cycles after the last beat.
        @(posedge clk);
        #1;
        send_set(1, NO_CH, NO_CH - 1);
        @(negedge clk);
        chk("nom_swap_e", 128'(swap), 128'd0);
        chk("nom_rdy_pend", 128'(coef_rdy), 128'd0);
        @(negedge clk);
        chk("nom_swap_e1", 128'(swap), 128'd1);
        for (int k = 0; k < NO_CH; k++) begin
            logic [BW_B-1:0] nb;
            nb = BW_B'(-(k + 1));
            chk("nom_a_k", 128'(a[k]), 128'(k + 1));
            chk("nom_b_k", 128'(b[k]), 128'(nb));
        end
        @(negedge clk);
        chk("nom_swap_pulse", 128'(swap), 128'd0);
        chk("nom_rdy_back", 128'(coef_rdy), 128'd1);
        drain();

        // Busy hold: pipe_busy stays high for 20 cycles after the last beat.
        pipe_busy = 1'b1;
        send_set(20, NO_CH, NO_CH - 1);
        repeat (20) begin
            @(negedge clk);
            chk("busy_rdy_low", 128'(coef_rdy), 128'd0);
            chk("busy_no_swap", 128'(swap), 128'd0);
        end
        @(posedge clk);
        #1;
        pipe_busy = 1'b0;
        @(negedge clk);
        chk("busy_no_swap_yet", 128'(swap), 128'd0);
        @(negedge clk);
        chk("busy_commit", 128'(swap), 128'd1);
        drain();

        // Short set: the last flag arrives on beat 5. It is followed by a valid set with every a=7.
        send_set(40, 5, 4);
        @(negedge clk);
        chk("short_err", 128'(err_len), 128'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < NO_CH; k++) send_beat(BW_A'(7), BW_B'(k), (k == NO_CH - 1), 1'b0);
        coef_vld = 1'b0;
        drain();
        for (int k = 0; k < NO_CH; k++) chk("short_a7", 128'(a[k]), 128'd7);

        // Long set: NO_CH beats with no last flag, then a valid set.
        send_set(60, NO_CH, -1);
        send_set(80, NO_CH, NO_CH - 1);
        drain();
        chk("long_ch0", 128'(a[0]), 128'd80);

        // Random gaps and random pipe_busy. The next set is often offered while the loader is in PEND.
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < NO_CH; k++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                pipe_busy = ($urandom_range(0, 2) == 0);
                send_beat(BW_A'($urandom), BW_B'($urandom), (k == NO_CH - 1), 1'b1);
            end
        end
        drain();

        // Reset mid-load: four beats of a new set are sent, then reset is applied.
        send_set(100, 4, -1);
        do_reset();
        @(negedge clk);
        chk("rst_a", 128'(a), 128'd0);
        chk("rst_b", 128'(b), 128'd0);
        chk("rst_valid", 128'(coef_valid), 128'd0);
        chk("rst_err", 128'(err_len), 128'd0);
        @(posedge clk);
        #1;
        send_set(200, NO_CH, NO_CH - 1);
        drain();
        chk("rst_ch0", 128'(a[0]), 128'd200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bn_coef_loader.md
# bn_coef_loader

Serial-to-parallel loader for the batch-norm/ReLU fixed-point stage's per-channel scale (`a`) and bias (`b`) coefficients. It accepts one (a, b) pair per beat over a valid/ready stream, assembles a full NO_CH set in a shadow bank, and commits it atomically to the active bank. The commit happens only when the downstream BN/ReLU pipeline reports idle, so a sample is never processed with a mix of old and new coefficients. The active bank drives the BN/ReLU block's `a`/`b` vector inputs directly.

## Interface
- NO_CH, 10, channels per coefficient set
- BW_A, 12, scale coefficient width (signed)
- BW_B, 12, bias coefficient width (signed)
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock is clk
- coef_vld  in  1  input beat valid
- coef_rdy  out  1  loader can accept a beat
- coef_a  in  BW_A  scale for current channel index
- coef_b  in  BW_B  bias for current channel index
- coef_last  in  1  marks final beat of a set
- pipe_busy  in  1  BN/ReLU pipeline holds in-flight data; integrator ties this to (vld_in OR any valid pipeline stage)
- a  out  NO_CH x BW_A  active scale vector; element i = channel i
- b  out  NO_CH x BW_B  active bias vector
- coef_valid  out  1  active bank holds a committed set
- swap  out  1  one-cycle pulse on the cycle after a commit edge
- err_len  out  1  sticky set-length error

## Operation
- State machine:
  - LOAD: coef_rdy=1. A beat is accepted when coef_vld & coef_rdy. Beat k writes coef_a/coef_b into shadow[idx]. idx is a counter of width clog2(NO_CH), min 1, and increments per accepted beat.
  - PEND: coef_rdy=0. The shadow bank is full and waits for pipe_busy=0.
- LOAD transitions on an accepted beat:
  - idx==NO_CH-1 and coef_last=1: go to PEND; idx<=0.
  - idx<NO_CH-1 and coef_last=0: idx<=idx+1; stay in LOAD.
  - idx<NO_CH-1 and coef_last=1 (short set): err_len<=1; idx<=0; stay in LOAD; the partial shadow is discarded and never committed.
  - idx==NO_CH-1 and coef_last=0 (long set): err_len<=1; idx<=0; stay in LOAD; the set is discarded. The next beats are treated as a new set starting at channel 0.
- PEND: on a clock edge with pipe_busy=0, all NO_CH a/b entries load from shadow in the same edge; coef_valid<=1; swap<=1; state<=LOAD.
- With pipe_busy=1, PEND holds indefinitely. a/b are unchanged.
- Coefficients are stored bit-exact with no arithmetic; sign is preserved as delivered.
- The active bank changes only at a commit edge. A discarded set never alters a/b.
- err_len is cleared only by rst.

## Timing
- Reset values: a=0, b=0, coef_valid=0, swap=0, err_len=0, idx=0, state=LOAD.
- coef_rdy is forced to 0 while rst=1 and is combinational from state otherwise. It is 1 in the first cycle after rst deasserts.
- Throughput: one beat per cycle in LOAD.
- Commit latency:
  - Final beat accepted at edge E gives PEND from E.
  - If pipe_busy=0 in the cycle after E, commit occurs at edge E+1. a/b show the new values and swap=1 in the cycle after E+1.
  - Minimum set period is therefore NO_CH+1 cycles.
- The first beat of the next set can be accepted at edge E+2 at the earliest, because coef_rdy is 1 again in the cycle after the commit.
- pipe_busy is sampled only in PEND. Its value during LOAD is ignored.
- coef_vld high while coef_rdy=0: no effect. The source must hold the beat until it is accepted.
- rst mid-load or in PEND: the shadow set is abandoned, the active bank clears to 0, coef_valid=0, and state returns to LOAD with idx=0.
- Shadow contents are don't-care after reset; they are fully rewritten before any commit.

## Test plan
- Nominal load:
  - Stimulus: 10 back-to-back beats, a=k+1, b=-(k+1), last on beat 9, pipe_busy=0.
  - Required: a[k]=k+1 and b[k]=-(k+1) (two's complement, 12-bit) appear 2 cycles after beat 9; swap is a single-cycle pulse; coef_valid=1.
- Busy hold:
  - Stimulus: same set with pipe_busy=1 for 20 cycles after the last beat.
  - Required: coef_rdy=0 and a/b unchanged for all 20 cycles; commit on the first edge with pipe_busy=0.
- Short set:
  - Stimulus: last asserted on beat 5, then a valid 10-beat set with a=7.
  - Required: err_len=1 after beat 5; a/b hold their prior values until the valid set commits all a[k]=7.
- Long set:
  - Stimulus: 10 beats with no last, then a valid set.
  - Required: err_len=1; the next beat writes channel 0; only the valid set commits.
- Backpressure and gaps:
  - Stimulus: random coef_vld gaps, with the next set offered while in PEND.
  - Required: no beat accepted while coef_rdy=0; beat order and channel mapping preserved.
- Reset mid-load:
  - Stimulus: rst after beat 4 of the second set, with set one already committed.
  - Required: a=b=0, coef_valid=0, err_len=0; the next full set loads from channel 0.
